regfile_sb: RTL and testbench

- Parametrised successor to the single-write MIPS datapath register file, for the pipelined CPU with devices and interrupts.
- Provides 2 read ports, 2 prioritised write ports, optional write-to-read bypass, and programmable reset values for $gp/$sp.
- Adds a per-register pending scoreboard: the decode stage marks a destination busy at issue, and writeback clears it. The hazard unit uses the busy flags to stall.
- Sits between decode (reads, issue) and writeback (ALU/CP0 path on port A, load/device path on port B).

---
 rtl/regfile_sb.sv | 131 +++++++++++++
 tb/tb_regfile_sb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two read ports, two prioritised write ports (B beats A),
// optional write-to-read bypass and a per-register pending scoreboard.

module regfile_sb_rdport #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [AW-1:0]               rs,
  input  logic [(2**AW)-1:0][DW-1:0]  rf,
  input  logic [(2**AW)-1:0]          pend,
  input  logic                        wa_en,
  input  logic [AW-1:0]               waddr_a,
  input  logic [DW-1:0]               wdata_a,
  input  logic                        wb_en,
  input  logic [AW-1:0]               waddr_b,
  input  logic [DW-1:0]               wdata_b,
  output logic [DW-1:0]               rd,
  output logic                        busy
);
  logic hit_a, hit_b, nz;

  assign nz    = (rs != '0);
  assign hit_a = BYPASS && wa_en && (waddr_a == rs);
  assign hit_b = BYPASS && wb_en && (waddr_b == rs);

  always_comb begin
    rd = '0;
    if (nz) begin
      if (hit_b)      rd = wdata_b;
      else if (hit_a) rd = wdata_a;
      else            rd = rf[rs];
    end
  end

  // forwarded data makes the pending flag stale for this read
  assign busy = nz && pend[rs] && !(hit_a || hit_b);
endmodule

module regfile_sb #(
  parameter int          DW      = 32,
  parameter int          AW      = 5,
  parameter int          GP_IDX  = 28,
  parameter logic [DW-1:0] GP_INIT = 32'h00001800,
  parameter int          SP_IDX  = 29,
  parameter logic [DW-1:0] SP_INIT = 32'h00002ffc,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [AW-1:0] RS1,
  input  logic [AW-1:0] RS2,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic          Busy1,
  output logic          Busy2,
  input  logic          WrA,
  input  logic [AW-1:0] WAddrA,
  input  logic [DW-1:0] WDataA,
  input  logic          WrB,
  input  logic [AW-1:0] WAddrB,
  input  logic [DW-1:0] WDataB,
  input  logic          Issue,
  input  logic [AW-1:0] IssueAddr,
  input  logic          Flush
);
  localparam int DEPTH = 2**AW;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][DW-1:0] rf;
  logic [DEPTH-1:0]         pend, pend_nxt;
  logic                     wa_en, wb_en;

  logic [NUM_RD-1:0][AW-1:0] rs_v;
  logic [NUM_RD-1:0][DW-1:0] rd_v;
  logic [NUM_RD-1:0]         busy_v;

  assign wa_en = WrA && (WAddrA != '0);
  assign wb_en = WrB && (WAddrB != '0);

  // B is assigned last so it wins an address collision
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        rf[i] <= (i == GP_IDX) ? GP_INIT : (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      if (wa_en) rf[WAddrA] <= WDataA;
      if (wb_en) rf[WAddrB] <= WDataB;
    end
  end

  always_comb begin
    pend_nxt = pend;
    if (Flush) begin
      pend_nxt = '0;
    end else begin
      if (wa_en) pend_nxt[WAddrA] = 1'b0;
      if (wb_en) pend_nxt[WAddrB] = 1'b0;
      if (Issue && (IssueAddr != '0)) pend_nxt[IssueAddr] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  assign rs_v = {RS2, RS1};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_sb_rdport #(.DW(DW), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .rs      (rs_v[p]),
      .rf      (rf),
      .pend    (pend),
      .wa_en   (wa_en),
      .waddr_a (WAddrA),
      .wdata_a (WDataA),
      .wb_en   (wb_en),
      .waddr_b (WAddrB),
      .wdata_b (WDataB),
      .rd      (rd_v[p]),
      .busy    (busy_v[p])
    );
  end

  assign RD1   = rd_v[0];
  assign RD2   = rd_v[1];
  assign Busy1 = busy_v[0];
  assign Busy2 = busy_v[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassing and non-bypassing instances share stimulus
// and are checked against an array-based model of the register file.

module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1, rs2, waddr_a, waddr_b, issue_addr;
  logic [31:0] wdata_a, wdata_b;
  logic        wr_a, wr_b, issue, flush;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        busy1, busy2, busy1_nb, busy2_nb;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_rf [32];
  bit          m_pend [32];

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .Clk(clk), .Rst_n(rst_n), .RS1(rs1), .RS2(rs2), .RD1(rd1), .RD2(rd2),
    .Busy1(busy1), .Busy2(busy2), .WrA(wr_a), .WAddrA(waddr_a), .WDataA(wdata_a),
    .WrB(wr_b), .WAddrB(waddr_b), .WDataB(wdata_b), .Issue(issue),
    .IssueAddr(issue_addr), .Flush(flush)
  );

  regfile_sb #(.BYPASS(1'b0)) u_dut_nb (
    .Clk(clk), .Rst_n(rst_n), .RS1(rs1), .RS2(rs2), .RD1(rd1_nb), .RD2(rd2_nb),
    .Busy1(busy1_nb), .Busy2(busy2_nb), .WrA(wr_a), .WAddrA(waddr_a), .WDataA(wdata_a),
    .WrB(wr_b), .WAddrB(waddr_b), .WDataB(wdata_b), .Issue(issue),
    .IssueAddr(issue_addr), .Flush(flush)
  );

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_rf[28] = 32'h00001800;
    m_rf[29] = 32'h00002ffc;
  endfunction

  function automatic void model_clock();
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      if (wr_a && waddr_a != 0) m_pend[waddr_a] = 1'b0;
      if (wr_b && waddr_b != 0) m_pend[waddr_b] = 1'b0;
      if (issue && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
    if (wr_a && waddr_a != 0) m_rf[waddr_a] = wdata_a;
    if (wr_b && waddr_b != 0) m_rf[waddr_b] = wdata_b;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit byp);
    if (rs == 0) return 32'h0;
    if (byp && wr_b && waddr_b == rs) return wdata_b;
    if (byp && wr_a && waddr_a == rs) return wdata_a;
    return m_rf[rs];
  endfunction

  function automatic logic exp_busy(input logic [4:0] rs, input bit byp);
    if (rs == 0) return 1'b0;
    if (byp && ((wr_b && waddr_b == rs) || (wr_a && waddr_a == rs))) return 1'b0;
    return m_pend[rs];
  endfunction

  task automatic idle();
    wr_a = 0; waddr_a = 0; wdata_a = 0;
    wr_b = 0; waddr_b = 0; wdata_b = 0;
    issue = 0; issue_addr = 0; flush = 0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; rs1 = 28; rs2 = 29;
    #1;
    checks += 4;
    if (rd1 !== 32'h00001800) begin errors++; $display("FAIL reset_gp: got %h want %h", rd1, 32'h00001800); end
    if (rd2 !== 32'h00002ffc) begin errors++; $display("FAIL reset_sp: got %h want %h", rd2, 32'h00002ffc); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b want 0", busy2); end
    rs1 = 5;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h want 0", rd1); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_zero_and_write();
    @(posedge clk); #1;
    idle();
    wr_a = 1; waddr_a = 0; wdata_a = 32'hFFFFFFFF; rs1 = 0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", rd1); end
    tick(); idle(); rs1 = 0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL r0_read: got %h want 0", rd1); end
    wr_a = 1; waddr_a = 7; wdata_a = 32'h12345678;
    tick(); idle(); rs1 = 7;
    #1;
    checks += 2;
    if (rd1 !== 32'h12345678) begin errors++; $display("FAIL wr_r7: got %h want %h", rd1, 32'h12345678); end
    if (rd1_nb !== 32'h12345678) begin errors++; $display("FAIL wr_r7_nb: got %h want %h", rd1_nb, 32'h12345678); end
  endtask

  task automatic test_collision();
    wr_a = 1; waddr_a = 9; wdata_a = 32'h11110000;
    tick(); idle();
    wr_a = 1; waddr_a = 9; wdata_a = 32'hAAAA0000;
    wr_b = 1; waddr_b = 9; wdata_b = 32'h0000BBBB;
    rs2 = 9;
    #1;
    checks += 2;
    if (rd2 !== 32'h0000BBBB) begin errors++; $display("FAIL coll_bypass: got %h want %h", rd2, 32'h0000BBBB); end
    if (rd2_nb !== 32'h11110000) begin errors++; $display("FAIL coll_nobypass: got %h want %h", rd2_nb, 32'h11110000); end
    tick(); idle(); rs2 = 9;
    #1;
    checks += 2;
    if (rd2 !== 32'h0000BBBB) begin errors++; $display("FAIL coll_stored: got %h want %h", rd2, 32'h0000BBBB); end
    if (rd2_nb !== 32'h0000BBBB) begin errors++; $display("FAIL coll_stored_nb: got %h want %h", rd2_nb, 32'h0000BBBB); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] old8;
    old8 = m_rf[8];
    issue = 1; issue_addr = 8;
    tick(); idle(); rs1 = 8;
    #1;
    checks += 2;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_issue: got %b want 1", busy1); end
    if (busy1_nb !== 1'b1) begin errors++; $display("FAIL sb_issue_nb: got %b want 1", busy1_nb); end
    wr_b = 1; waddr_b = 8; wdata_b = 32'h55;
    #1;
    checks += 4;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_fwd_busy: got %b want 0", busy1); end
    if (rd1 !== 32'h55) begin errors++; $display("FAIL sb_fwd_data: got %h want %h", rd1, 32'h55); end
    if (busy1_nb !== 1'b1) begin errors++; $display("FAIL sb_fwd_busy_nb: got %b want 1", busy1_nb); end
    if (rd1_nb !== old8) begin errors++; $display("FAIL sb_fwd_data_nb: got %h want %h", rd1_nb, old8); end
    tick(); idle(); rs1 = 8;
    #1;
    checks += 2;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", busy1); end
    if (busy1_nb !== 1'b0) begin errors++; $display("FAIL sb_clear_nb: got %b want 0", busy1_nb); end
  endtask

  task automatic test_issue_write_flush();
    issue = 1; issue_addr = 10;
    wr_a = 1; waddr_a = 10; wdata_a = 32'h77;
    tick(); idle(); rs1 = 10;
    #1;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL issue_over_write: got %b want 1", busy1); end
    flush = 1; issue = 1; issue_addr = 11;
    tick(); idle(); rs1 = 10; rs2 = 11;
    #1;
    checks += 3;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL flush_r10: got %b want 0", busy1); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL flush_r11: got %b want 0", busy2); end
    if (rd1 !== 32'h77) begin errors++; $display("FAIL issue_write_data: got %h want %h", rd1, 32'h77); end
  endtask

  task automatic test_async_reset();
    wr_a = 1; waddr_a = 3; wdata_a = 32'hDEAD;
    issue = 1; issue_addr = 4;
    tick(); idle(); rs1 = 3; rs2 = 4;
    #1;
    checks += 2;
    if (rd1 !== 32'hDEAD) begin errors++; $display("FAIL ar_pre_data: got %h want %h", rd1, 32'hDEAD); end
    if (busy2 !== 1'b1) begin errors++; $display("FAIL ar_pre_busy: got %b want 1", busy2); end
    rst_n = 0;
    #1;
    checks += 3;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL ar_data: got %h want 0", rd1); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy2); end
    if (busy2_nb !== 1'b0) begin errors++; $display("FAIL ar_busy_nb: got %b want 0", busy2_nb); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic        eb;
    for (int n = 0; n < 400; n++) begin
      rs1 = 5'($urandom_range(0, 11));
      rs2 = 5'($urandom_range(0, 11));
      wr_a = 1'($urandom_range(0, 1));
      waddr_a = 5'($urandom_range(0, 11));
      wdata_a = $urandom;
      wr_b = 1'($urandom_range(0, 1));
      waddr_b = ($urandom_range(0, 3) == 0) ? waddr_a : 5'($urandom_range(0, 11));
      wdata_b = $urandom;
      issue = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 11));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      checks += 8;
      e = exp_rd(rs1, 1'b1);
      if (rd1 !== e) begin errors++; $display("FAIL rnd_rd1 n=%0d rs=%0d: got %h want %h", n, rs1, rd1, e); end
      e = exp_rd(rs2, 1'b1);
      if (rd2 !== e) begin errors++; $display("FAIL rnd_rd2 n=%0d rs=%0d: got %h want %h", n, rs2, rd2, e); end
      e = exp_rd(rs1, 1'b0);
      if (rd1_nb !== e) begin errors++; $display("FAIL rnd_rd1_nb n=%0d rs=%0d: got %h want %h", n, rs1, rd1_nb, e); end
      e = exp_rd(rs2, 1'b0);
      if (rd2_nb !== e) begin errors++; $display("FAIL rnd_rd2_nb n=%0d rs=%0d: got %h want %h", n, rs2, rd2_nb, e); end
      eb = exp_busy(rs1, 1'b1);
      if (busy1 !== eb) begin errors++; $display("FAIL rnd_busy1 n=%0d rs=%0d: got %b want %b", n, rs1, busy1, eb); end
      eb = exp_busy(rs2, 1'b1);
      if (busy2 !== eb) begin errors++; $display("FAIL rnd_busy2 n=%0d rs=%0d: got %b want %b", n, rs2, busy2, eb); end
      eb = exp_busy(rs1, 1'b0);
      if (busy1_nb !== eb) begin errors++; $display("FAIL rnd_busy1_nb n=%0d rs=%0d: got %b want %b", n, rs1, busy1_nb, eb); end
      eb = exp_busy(rs2, 1'b0);
      if (busy2_nb !== eb) begin errors++; $display("FAIL rnd_busy2_nb n=%0d rs=%0d: got %b want %b", n, rs2, busy2_nb, eb); end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 0; rs1 = 0; rs2 = 0;
    idle();
    #12;
    test_reset();
    test_zero_and_write();
    test_collision();
    test_scoreboard();
    test_issue_write_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
